data_source: RTL
================

# data_source

AXI4-Stream traffic generator that produces a programmable burst of data beats for the downstream stream sink and any other AXI4-Stream slave in the test designs. A single-cycle START latches a mode, seed, beat count and inter-beat gap. The block then emits LENGTH beats with a deterministic data pattern, marks the final beat with tlast, and reports completion. The stream protocol is honoured under arbitrary backpressure.

## Interface
- DATA_WIDTH, 32, width of tdata and SEED
- LEN_WIDTH, 16, width of LENGTH and BEAT_COUNT
- GAP_WIDTH, 4, width of GAP
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low; clock ACLK
- START  in  1  start pulse; sampled only in IDLE
- MODE  in  2  pattern: 0 counter, 1 constant, 2 rotate-left, 3 alternate-invert
- SEED  in  DATA_WIDTH  first beat value
- LENGTH  in  LEN_WIDTH  beats to send; 0 = empty transfer
- GAP  in  GAP_WIDTH  idle cycles inserted after each handshake
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- BEAT_COUNT  out  LEN_WIDTH  handshakes completed in current/last transfer
- AXIS_PORT  axi4s_if.master  —  drives tvalid, tdata, tlast; samples tready

## Operation
- States: IDLE, SEND, GAP_WAIT.
- **IDLE**
  - START=1 latches MODE, SEED, LENGTH and GAP.
  - BEAT_COUNT clears to 0.
  - If LENGTH=0: stay in IDLE and pulse DONE next cycle. No tvalid is driven.
  - Otherwise go to SEND with tdata=SEED and BUSY=1.
- **SEND**
  - tvalid=1.
  - tlast=1 when BEAT_COUNT = latched LENGTH-1.
  - A handshake (tvalid & tready) increments BEAT_COUNT and advances the pattern.
  - On the last-beat handshake: go to IDLE, BUSY=0, DONE=1 for one cycle.
  - Otherwise, if GAP=0, stay in SEND with the next beat. If GAP>0, go to GAP_WAIT.
- **GAP_WAIT**
  - tvalid=0.
  - Down-counter loads GAP on entry and returns to SEND after GAP cycles.
- **Pattern update**, applied on each handshake; arithmetic is modulo 2^DATA_WIDTH:
  - counter: d+1, with wrap-around from all-ones to 0
  - constant: d
  - rotate-left: {d[W-2:0], d[W-1]}
  - alternate-invert: ~d
- **Protocol rules**
  - tvalid never depends combinationally on tready.
  - While tvalid=1 and tready=0, tdata and tlast are held stable.
  - tvalid is never withdrawn before a handshake.
- START while BUSY=1 is ignored.
- START in the DONE cycle is accepted, since the block is already in IDLE.
- Input changes after latching have no effect on a running transfer.
- BEAT_COUNT holds its final value until the next accepted START.
- **Reset**, including reset applied mid-transfer:
  - tvalid=0, tdata=0, tlast=0, BUSY=0, DONE=0, BEAT_COUNT=0, state IDLE.
  - A partial burst is abandoned; no tlast is sent.
- LENGTH = 2^LEN_WIDTH-1 is supported. BEAT_COUNT cannot overflow.

## Timing
- All outputs are registered.
- START sampled at cycle N gives first tvalid and BUSY at N+1.
- GAP=0 with tready held high: one beat per cycle. Final handshake at N+LENGTH; DONE at N+LENGTH+1.
- GAP=g: each non-final handshake at cycle k gives tvalid=0 on k+1..k+g and the next beat at k+g+1.
- Handshake-driven traffic with tready=1 only every other cycle is sustained without data loss.
- A handshake at cycle k gives the updated BEAT_COUNT at k+1.
- LENGTH=0: DONE at N+1, BUSY stays 0.
- ARESETN low at cycle k gives reset values from k+1.

## Test plan
- **Counter burst.** MODE=0, SEED=0x10, LENGTH=4, GAP=0, tready=1.
  - Beats 0x10, 0x11, 0x12, 0x13 on N+1..N+4, tlast only on 0x13.
  - DONE at N+5, BEAT_COUNT=4.
- **Patterns, LENGTH=3.**
  - Rotate SEED=0x80000001 gives 0x80000001, 0x00000003, 0x00000006.
  - Alternate SEED=0xA5A5A5A5 gives 0xA5A5A5A5, 0x5A5A5A5A, 0xA5A5A5A5.
  - Counter SEED=0xFFFFFFFF gives 0xFFFFFFFF, 0x00000000, 0x00000001.
- **Gap.** GAP=2, LENGTH=3, tready=1.
  - tvalid high at N+1, N+4, N+7; low elsewhere.
  - DONE at N+8.
- **Backpressure.** LENGTH=64 into a slave whose tready pulses one cycle after tvalid plus random 0–5-cycle stalls.
  - tdata and tlast stable during every stall.
  - 64 counter values received in order, exactly one tlast.
- **Edge starts.**
  - LENGTH=0: DONE at N+1, no tvalid.
  - START during BUSY is ignored.
  - START in the DONE cycle launches a new burst at the next cycle.
- **Reset mid-transfer.** ARESETN low after beat 2 of 8.
  - Next cycle: all outputs zero, state IDLE.
  - A following START with SEED=0 begins at 0x0, BEAT_COUNT restarts from 0.

Source files
------------

// File: rtl/axi4s_if.sv
// AXI4-Stream bundle carrying tvalid/tready/tdata/tlast between a master and a slave.
interface axi4s_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/data_source.sv
// AXI4-Stream burst generator: on START it emits LENGTH patterned beats, optional
// idle gaps between handshakes, tlast on the final beat and a DONE pulse.
module data_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  START,
  input  logic [1:0]            MODE,
  input  logic [DATA_WIDTH-1:0] SEED,
  input  logic [LEN_WIDTH-1:0]  LENGTH,
  input  logic [GAP_WIDTH-1:0]  GAP,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [LEN_WIDTH-1:0]  BEAT_COUNT,
  axi4s_if.master               AXIS_PORT
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_GAP_WAIT = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tvalid, w_tvalid_nxt;
  logic                  r_tlast,  w_tlast_nxt;
  logic [DATA_WIDTH-1:0] r_tdata,  w_tdata_nxt;
  logic                  r_busy,   w_busy_nxt;
  logic                  r_done,   w_done_nxt;
  logic [LEN_WIDTH-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [GAP_WIDTH-1:0]  r_gap_cnt,  w_gap_cnt_nxt;

  logic [1:0]            r_mode, w_mode_nxt;
  logic [LEN_WIDTH-1:0]  r_len,  w_len_nxt;
  logic [GAP_WIDTH-1:0]  r_gap,  w_gap_nxt;

  logic                  w_hs;
  logic [LEN_WIDTH-1:0]  w_cnt_inc;
  logic [LEN_WIDTH-1:0]  w_len_m1;

  function automatic logic [DATA_WIDTH-1:0] f_next_beat(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [DATA_WIDTH-1:0] res;
    case (mode)
      2'd0:    res = d + DATA_ONE;
      2'd1:    res = d;
      2'd2:    res = {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
      default: res = ~d;
    endcase
    return res;
  endfunction

  assign w_hs      = r_tvalid & AXIS_PORT.tready;
  assign w_cnt_inc = r_beat_cnt + LEN_ONE;
  assign w_len_m1  = r_len - LEN_ONE;

  always_comb begin
    w_state_nxt    = r_state;
    w_tvalid_nxt   = r_tvalid;
    w_tlast_nxt    = r_tlast;
    w_tdata_nxt    = r_tdata;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_mode_nxt     = r_mode;
    w_len_nxt      = r_len;
    w_gap_nxt      = r_gap;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_mode_nxt     = MODE;
          w_len_nxt      = LENGTH;
          w_gap_nxt      = GAP;
          w_beat_cnt_nxt = '0;
          if (LENGTH == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_SEND;
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = SEED;
            w_tlast_nxt  = (LENGTH == LEN_ONE);
            w_busy_nxt   = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (w_hs) begin
          w_beat_cnt_nxt = w_cnt_inc;
          w_tdata_nxt    = f_next_beat(r_mode, r_tdata);
          if (r_tlast) begin
            w_state_nxt  = S_IDLE;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
          end else begin
            // tlast for the next beat is resolved now so it is ready when tvalid rises.
            w_tlast_nxt = (w_cnt_inc == w_len_m1);
            if (r_gap == '0) begin
              w_tvalid_nxt = 1'b1;
            end else begin
              w_state_nxt   = S_GAP_WAIT;
              w_tvalid_nxt  = 1'b0;
              w_gap_cnt_nxt = r_gap;
            end
          end
        end
      end

      S_GAP_WAIT: begin
        if (r_gap_cnt == GAP_ONE) begin
          w_state_nxt  = S_SEND;
          w_tvalid_nxt = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state    <= S_IDLE;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tlast    <= w_tlast_nxt;
      r_tdata    <= w_tdata_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  // Latched transfer configuration is only consulted while BUSY, so it needs no reset.
  always_ff @(posedge ACLK) begin
    r_mode <= w_mode_nxt;
    r_len  <= w_len_nxt;
    r_gap  <= w_gap_nxt;
  end

  assign AXIS_PORT.tvalid = r_tvalid;
  assign AXIS_PORT.tlast  = r_tlast;
  assign AXIS_PORT.tdata  = r_tdata;
  assign BUSY             = r_busy;
  assign DONE             = r_done;
  assign BEAT_COUNT       = r_beat_cnt;

endmodule
